// File: rtl/usr_sw_pkg.sv
// usr_sw_pkg: shared constants and FSM state type for the DIP switch
// input conditioner (usr_sw_conditioner and its per-bit debouncer).
package usr_sw_pkg;

  localparam int unsigned SW_WIDTH           = 8;
  localparam int unsigned SW_SYNC_STAGES     = 2;
  localparam int unsigned SW_DEBOUNCE_100MHZ = 1000000;  // 10 ms at 100 MHz

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } sw_state_e;

endpackage

// File: rtl/sw_bit_debounce.sv
// sw_bit_debounce: one switch bit -- synchronizer chain, debounce counter
// and stable flop.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   sw_i       raw asynchronous switch pin
//   load       prime strobe: copy synchronizer output straight into stable
//   run        debounce enable (counter held at 0 while low)
//   stable     debounced level (registered)
//   flip       high in the cycle whose closing edge toggles stable
module sw_bit_debounce
  import usr_sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  input  logic load,
  input  logic run,
  output logic stable,
  output logic flip
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sw_i};
    cnt_d    = '0;
    stable_d = stable_q;
    flip     = 1'b0;
    if (load) begin
      stable_d = sync_out;
    end else if (run && (sync_out != stable_q)) begin
      // Flip on the DEBOUNCE_CYCLES-th consecutive differing cycle.
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
        flip     = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/usr_sw_conditioner.sv
// usr_sw_conditioner: synchronizes and debounces the board DIP switches,
// publishing a stable switch word and a valid/ready change-event stream.
//
// Ports:
//   sys0_clk      100 MHz clock
//   sys0_rst      asynchronous active-high reset
//   usr_sw_i      raw switch pins (asynchronous)
//   sw_primed     high once sw_stable reflects the real switch state
//   sw_stable     debounced switch word
//   sw_chg_valid  change event available
//   sw_chg_ready  consumer accepts event
//   sw_chg_mask   bits changed since the last accepted event
//   sw_chg_value  sw_stable captured with the event
module usr_sw_conditioner
  import usr_sw_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_100MHZ
) (
  input  logic             sys0_clk,
  input  logic             sys0_rst,
  input  logic [WIDTH-1:0] usr_sw_i,
  output logic             sw_primed,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_chg_valid,
  input  logic             sw_chg_ready,
  output logic [WIDTH-1:0] sw_chg_mask,
  output logic [WIDTH-1:0] sw_chg_value
);

  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);

  sw_state_e          state_q, state_d;
  logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
  logic               primed_q, primed_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   value_q, value_d;

  logic               prime_load;
  logic               run;
  logic [WIDTH-1:0]   stable_w;
  logic [WIDTH-1:0]   flip_w;

  genvar g;
  for (g = 0; g < WIDTH; g++) begin : g_bit
    sw_bit_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (sys0_clk),
      .rst   (sys0_rst),
      .sw_i  (usr_sw_i[g]),
      .load  (prime_load),
      .run   (run),
      .stable(stable_w[g]),
      .flip  (flip_w[g])
    );
  end

  // Prime FSM: wait for the synchronizers to fill, then load stable directly.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    prime_load  = 1'b0;
    run         = (state_q == RUN);
    case (state_q)
      PRIME: begin
        if (prime_cnt_q == PRIME_W'(SYNC_STAGES)) begin
          prime_load = 1'b1;
          primed_d   = 1'b1;
          state_d    = RUN;
        end else begin
          prime_cnt_d = prime_cnt_q + PRIME_W'(1);
        end
      end
      RUN: ;
      default: state_d = PRIME;
    endcase
  end

  // Event path: 1-deep output register; changes arriving while stalled
  // accumulate in pend and are merged into the next event.
  always_comb begin
    pend_d  = pend_q;
    valid_d = valid_q;
    mask_d  = mask_q;
    value_d = value_q;
    if (run) begin
      if (!valid_q || sw_chg_ready) begin
        mask_d  = pend_q | flip_w;
        value_d = stable_w ^ flip_w;
        valid_d = |(pend_q | flip_w);
        pend_d  = '0;
      end else begin
        pend_d  = pend_q | flip_w;
      end
    end
  end

  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      state_q     <= PRIME;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      pend_q      <= '0;
      valid_q     <= 1'b0;
      mask_q      <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      pend_q      <= pend_d;
      valid_q     <= valid_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
    end
  end

  assign sw_primed    = primed_q;
  assign sw_stable    = stable_w;
  assign sw_chg_valid = valid_q;
  assign sw_chg_mask  = mask_q;
  assign sw_chg_value = value_q;

endmodule

// File: tb/tb_usr_sw_conditioner.sv
module tb_usr_sw_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] usr_sw;
  logic       ready;
  logic       primed;
  logic [7:0] stable;
  logic       valid;
  logic [7:0] mask;
  logic [7:0] value;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] value;
  } ev_t;

  ev_t exp_q[$];

  usr_sw_conditioner #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .sys0_clk    (clk),
    .sys0_rst    (rst),
    .usr_sw_i    (usr_sw),
    .sw_primed   (primed),
    .sw_stable   (stable),
    .sw_chg_valid(valid),
    .sw_chg_ready(ready),
    .sw_chg_mask (mask),
    .sw_chg_value(value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input logic [7:0] m, input logic [7:0] v);
    ev_t e;
    e.mask  = m;
    e.value = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted event is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got mask=%h value=%h expected no event (t=%0t)",
                 mask, value, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_mask", 32'(mask), 32'(e.mask));
        chk("ev_value", 32'(value), 32'(e.value));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    usr_sw = 8'hA5;
    ready  = 1'b1;
    tick(4);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_stable", 32'(stable), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);

    // Priming
    rst = 1'b0;
    tick(2);
    chk("prime_early", 32'(primed), 32'd0);
    tick(1);
    chk("prime_primed", 32'(primed), 32'd1);
    chk("prime_stable", 32'(stable), 32'hA5);
    tick(5);
    chk("prime_no_event", 32'(valid), 32'd0);

    // Clean toggle of bit0
    usr_sw = 8'hA4;
    expect_ev(8'h01, 8'hA4);
    tick(17);
    chk("toggle_before", 32'(stable), 32'hA5);
    tick(1);
    chk("toggle_at18", 32'(stable), 32'hA4);
    chk("toggle_valid", 32'(valid), 32'd1);
    tick(1);
    chk("toggle_pulse", 32'(valid), 32'd0);
    tick(3);

    // Glitch rejection on bit7, then a real change
    usr_sw = 8'h24;
    tick(15);
    usr_sw = 8'hA4;
    tick(20);
    chk("glitch_stable", 32'(stable), 32'hA4);
    usr_sw = 8'h24;
    expect_ev(8'h80, 8'h24);
    tick(18);
    chk("glitch_real", 32'(stable), 32'h24);
    tick(3);

    // Stall and merge
    ready  = 1'b0;
    usr_sw = 8'h26;
    expect_ev(8'h02, 8'h26);
    tick(18);
    chk("stall_stable1", 32'(stable), 32'h26);
    chk("stall_valid1", 32'(valid), 32'd1);
    chk("stall_mask1", 32'(mask), 32'h02);
    usr_sw = 8'h22;
    expect_ev(8'h04, 8'h22);
    tick(18);
    chk("stall_stable2", 32'(stable), 32'h22);
    chk("stall_hold_mask", 32'(mask), 32'h02);
    chk("stall_hold_value", 32'(value), 32'h26);
    ready = 1'b1;
    tick(1);
    chk("merge_valid", 32'(valid), 32'd1);
    chk("merge_mask", 32'(mask), 32'h04);
    tick(1);
    chk("merge_drained", 32'(valid), 32'd0);
    tick(3);

    // Simultaneous accept and change
    ready  = 1'b0;
    usr_sw = 8'h32;
    expect_ev(8'h10, 8'h32);
    tick(18);
    chk("sim_first_valid", 32'(valid), 32'd1);
    usr_sw = 8'h3A;
    expect_ev(8'h08, 8'h3A);
    tick(17);
    chk("sim_before", 32'(stable), 32'h32);
    ready = 1'b1;
    tick(1);
    chk("sim_stable", 32'(stable), 32'h3A);
    chk("sim_valid", 32'(valid), 32'd1);
    chk("sim_mask", 32'(mask), 32'h08);
    tick(3);

    // Multi-bit change
    usr_sw = 8'h5A;
    expect_ev(8'h60, 8'h5A);
    tick(18);
    chk("multi_stable", 32'(stable), 32'h5A);
    tick(3);

    // Reset in the middle of a debounce (counter at 10)
    usr_sw = 8'h5B;
    tick(12);
    rst = 1'b1;
    #1;
    chk("mrst_primed", 32'(primed), 32'd0);
    chk("mrst_stable", 32'(stable), 32'h00);
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_mask", 32'(mask), 32'h00);
    chk("mrst_value", 32'(value), 32'h00);
    tick(3);
    rst = 1'b0;
    tick(3);
    chk("reprime_primed", 32'(primed), 32'd1);
    chk("reprime_stable", 32'(stable), 32'h5B);
    tick(20);
    chk("reprime_hold", 32'(stable), 32'h5B);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
